// File: rtl/uart_imem_loader_if.sv
// rtl/uart_imem_loader_if.sv - UART byte-port and imem programming-port bundle
interface uart_imem_loader_if;
  logic        rx_data_present;
  logic [7:0]  uart_dout;
  logic        rx_ren;
  logic        tx_full;
  logic        tx_wen;
  logic [7:0]  uart_din;
  logic        imem_en;
  logic        imem_prog_ena;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;

  modport master (
    input  rx_data_present, uart_dout, tx_full,
    output rx_ren, tx_wen, uart_din, imem_en, imem_prog_ena, imem_addr, imem_din
  );

  modport slave (
    output rx_data_present, uart_dout, tx_full,
    input  rx_ren, tx_wen, uart_din, imem_en, imem_prog_ena, imem_addr, imem_din
  );
endinterface

// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - UART boot loader writing a framed image into imem
module uart_imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 4096,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 5_000_000
) (
  input  logic                clk,
  input  logic                Rst_n,
  input  logic                enable,
  uart_imem_loader_if.master  bus,
  output logic                core_hold,
  output logic                done,
  output logic                err
);

  localparam int              TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TMAX   = TW'(TIMEOUT_CYC);
  localparam logic [16:0]     MAXW   = 17'(MAX_WORDS);
  localparam logic [7:0]      CODE_K = 8'h4B;
  localparam logic [7:0]      CODE_E = 8'h45;
  localparam logic [7:0]      CODE_T = 8'h54;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_CNT0, S_CNT1, S_DATA, S_WRITE, S_CSUM, S_RESP, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic            popped_q;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [7:0]      cnt_lo_q, cnt_lo_d;
  logic [15:0]     count_q, count_d;
  logic [15:0]     idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      code_q, code_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            want_byte, timed, timeout, pop, abort;
  logic [7:0]      rx_byte;
  logic [16:0]     cnt_full;

  always_comb begin
    state_d            = state_q;
    bcnt_d             = bcnt_q;
    cnt_lo_d           = cnt_lo_q;
    count_d            = count_q;
    idx_d              = idx_q;
    word_d             = word_q;
    sum_d              = sum_q;
    code_d             = code_q;
    bus.rx_ren         = 1'b0;
    bus.tx_wen         = 1'b0;
    bus.uart_din       = 8'h00;
    bus.imem_en        = 1'b0;
    bus.imem_prog_ena  = 1'b0;
    bus.imem_addr      = 32'h0;
    bus.imem_din       = 32'h0;

    rx_byte   = bus.uart_dout;
    cnt_full  = {1'b0, rx_byte, cnt_lo_q};
    want_byte = (state_q == S_SYNC) || (state_q == S_CNT0) || (state_q == S_CNT1) ||
                (state_q == S_DATA) || (state_q == S_CSUM);
    timed     = (state_q == S_CNT0) || (state_q == S_CNT1) || (state_q == S_DATA) ||
                (state_q == S_WRITE) || (state_q == S_CSUM);
    timeout   = timed && want_byte && (timer_q >= TMAX);
    abort     = !enable && (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    // popped_q enforces the one-cycle gap the FWFT FIFO needs to present the next byte
    pop       = enable && want_byte && !timeout && bus.rx_data_present && !popped_q;
    bus.rx_ren = pop;
    timer_d   = (pop || !timed) ? '0 : timer_q + TW'(1);

    case (state_q)
      S_IDLE: if (enable) begin
        state_d = S_SYNC;
        idx_d   = 16'd0;
        sum_d   = 8'd0;
        bcnt_d  = 2'd0;
      end
      S_SYNC: if (pop && rx_byte == SYNC_BYTE) state_d = S_CNT0;
      S_CNT0: if (pop) begin
        cnt_lo_d = rx_byte;
        state_d  = S_CNT1;
      end
      S_CNT1: if (pop) begin
        count_d = cnt_full[15:0];
        if (cnt_full == 17'd0 || cnt_full > MAXW) begin
          code_d  = CODE_E;
          state_d = S_RESP;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (pop) begin
        word_d = {rx_byte, word_q[31:8]};
        sum_d  = sum_q + rx_byte;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        bus.imem_en       = 1'b1;
        bus.imem_prog_ena = 1'b1;
        bus.imem_addr     = BASE_ADDR + {14'd0, idx_q, 2'b00};
        bus.imem_din      = word_q;
        idx_d             = idx_q + 16'd1;
        state_d           = (idx_q + 16'd1 == count_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: if (pop) begin
        code_d  = (rx_byte == sum_q) ? CODE_K : CODE_E;
        state_d = S_RESP;
      end
      S_RESP: if (!bus.tx_full) begin
        bus.tx_wen   = 1'b1;
        bus.uart_din = code_q;
        state_d      = (code_q == CODE_K) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      code_d  = CODE_T;
      state_d = S_RESP;
    end

    // an abort must not leak a final write or status byte in its own cycle
    if (abort) begin
      state_d           = S_IDLE;
      bus.tx_wen        = 1'b0;
      bus.uart_din      = 8'h00;
      bus.imem_en       = 1'b0;
      bus.imem_prog_ena = 1'b0;
      bus.imem_addr     = 32'h0;
      bus.imem_din      = 32'h0;
    end

    core_hold = (state_q != S_IDLE) && (state_q != S_DONE);
    done      = (state_q == S_DONE);
    err       = (state_q == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      popped_q <= 1'b0;
      bcnt_q   <= 2'd0;
      cnt_lo_q <= 8'd0;
      count_q  <= 16'd0;
      idx_q    <= 16'd0;
      word_q   <= 32'd0;
      sum_q    <= 8'd0;
      code_q   <= 8'd0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      popped_q <= pop;
      bcnt_q   <= bcnt_d;
      cnt_lo_q <= cnt_lo_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      sum_q    <= sum_d;
      code_q   <= code_d;
      timer_q  <= timer_d;
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - randomized self-checking bench for uart_imem_loader
module tb_uart_imem_loader;
  localparam int          TO = 200;
  localparam int          MW = 16;
  localparam logic [31:0] BA = 32'h0000_0200;

  logic clk = 1'b0;
  logic Rst_n = 1'b0;
  logic enable = 1'b0;
  logic core_hold, done, err;

  uart_imem_loader_if bus();

  uart_imem_loader #(
    .BASE_ADDR(BA), .MAX_WORDS(MW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .Rst_n(Rst_n), .enable(enable), .bus(bus),
    .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  frame[$];
  logic [7:0]  build_sum;
  bit          pop_pending = 1'b0;
  int          cyc = 0;
  int          last_pop_cyc = 0;
  int          tx_cyc = 0;
  int          ren_viol = 0;
  bit          prev_ren = 1'b0;
  logic [31:0] wa_q[$], wd_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] exp_a[$], exp_d[$];
  logic [7:0]  exp_code;

  initial begin
    bus.rx_data_present = 1'b0;
    bus.uart_dout       = 8'h00;
    bus.tx_full         = 1'b0;
  end

  always @(negedge clk) begin
    cyc++;
    if (bus.rx_ren === 1'b1) begin
      pop_pending  = 1'b1;
      last_pop_cyc = cyc;
      if (prev_ren) ren_viol++;
    end
    prev_ren = (bus.rx_ren === 1'b1);
    if (bus.imem_en === 1'b1 && bus.imem_prog_ena === 1'b1) begin
      wa_q.push_back(bus.imem_addr);
      wd_q.push_back(bus.imem_din);
    end
    if (bus.tx_wen === 1'b1) begin
      tx_q.push_back(bus.uart_din);
      tx_cyc = cyc;
    end
  end

  // first-word fall-through RX FIFO model
  always @(posedge clk) begin
    #1;
    if (pop_pending && rx_q.size() > 0) void'(rx_q.pop_front());
    pop_pending = 1'b0;
    bus.rx_data_present = (rx_q.size() > 0);
    bus.uart_dout = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // Frame parser working directly from the protocol description.
  task automatic model();
    int i = 0;
    int n;
    logic [7:0] s;
    logic [31:0] w;
    exp_a.delete();
    exp_d.delete();
    while (i < frame.size() && frame[i] != 8'hA5) i++;
    i++;
    if (i + 2 > frame.size()) begin exp_code = 8'h54; return; end
    n = int'(frame[i]) + 256 * int'(frame[i+1]);
    i += 2;
    if (n == 0 || n > MW) begin exp_code = 8'h45; return; end
    s = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (i + 4 > frame.size()) begin exp_code = 8'h54; return; end
      w = 32'(frame[i]) + 32'(frame[i+1]) * 256 + 32'(frame[i+2]) * 65536 + 32'(frame[i+3]) * 16777216;
      exp_a.push_back(BA + 32'(4 * k));
      exp_d.push_back(w);
      for (int b = 0; b < 4; b++) s = s + frame[i+b];
      i += 4;
    end
    if (i >= frame.size()) begin exp_code = 8'h54; return; end
    exp_code = (frame[i] == s) ? 8'h4B : 8'h45;
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      frame.push_back(w[8*b +: 8]);
      build_sum = build_sum + w[8*b +: 8];
    end
  endtask

  task automatic start_frame(input int n);
    frame.delete();
    build_sum = 8'h00;
    frame.push_back(8'hA5);
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    tx_q.delete();
  endtask

  task automatic wait_end(input string name);
    int k = 0;
    while (!(done || err) && k < 3000) begin @(negedge clk); k++; end
    total++;
    if (!(done || err)) begin
      bad++;
      $display("FAIL %s end-wait: done=%b err=%b after %0d cycles, required done or err", name, done, err, k);
    end
  endtask

  task automatic check_result(input string name);
    total++;
    if (wa_q.size() != exp_a.size()) begin
      bad++;
      $display("FAIL %s write-count: got %0d want %0d", name, wa_q.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        total++;
        if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
          bad++;
          $display("FAIL %s write[%0d]: got %h@%h want %h@%h", name, i, wd_q[i], wa_q[i], exp_d[i], exp_a[i]);
        end
      end
    end
    total++;
    if (tx_q.size() != 1) begin
      bad++;
      $display("FAIL %s tx-count: got %0d want 1", name, tx_q.size());
    end else begin
      total++;
      if (tx_q[0] !== exp_code) begin
        bad++;
        $display("FAIL %s tx-code: got %h want %h", name, tx_q[0], exp_code);
      end
    end
    total++;
    if (done !== (exp_code == 8'h4B) || err !== (exp_code != 8'h4B) || core_hold !== (exp_code != 8'h4B)) begin
      bad++;
      $display("FAIL %s flags: done=%b err=%b hold=%b want code %h", name, done, err, core_hold, exp_code);
    end
    total++;
    if (rx_q.size() != 0) begin
      bad++;
      $display("FAIL %s rx-drain: %0d bytes left want 0", name, rx_q.size());
    end
  endtask

  task automatic release_enable(input string name);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (done !== 1'b0 || err !== 1'b0 || core_hold !== 1'b0) begin
      bad++;
      $display("FAIL %s release: done=%b err=%b hold=%b want 000", name, done, err, core_hold);
    end
  endtask

  task automatic run_frame(input string name);
    clear_mon();
    model();
    @(negedge clk);
    enable = 1'b1;
    foreach (frame[i]) rx_q.push_back(frame[i]);
    wait_end(name);
    @(negedge clk);
    check_result(name);
    release_enable(name);
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (core_hold !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bus.rx_ren !== 1'b0 ||
        bus.tx_wen !== 1'b0 || bus.uart_din !== 8'h00 || bus.imem_en !== 1'b0 ||
        bus.imem_prog_ena !== 1'b0 || bus.imem_addr !== 32'h0 || bus.imem_din !== 32'h0) begin
      bad++;
      $display("FAIL %s outputs: hold=%b done=%b err=%b ren=%b wen=%b din=%h en=%b pe=%b a=%h d=%h want all zero",
               name, core_hold, done, err, bus.rx_ren, bus.tx_wen, bus.uart_din, bus.imem_en,
               bus.imem_prog_ena, bus.imem_addr, bus.imem_din);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    Rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frames();
    start_frame(2);
    add_word(32'h1234_5678);
    add_word(32'hDEAD_BEEF);
    frame.push_back(build_sum);
    run_frame("good_two_words");

    start_frame(2);
    add_word(32'h1234_5678);
    add_word(32'hDEAD_BEEF);
    frame.push_back(8'h00);
    run_frame("bad_checksum");

    frame.delete();
    build_sum = 8'h00;
    frame.push_back(8'h00);
    frame.push_back(8'hFF);
    frame.push_back(8'hA5);
    frame.push_back(8'h01);
    frame.push_back(8'h00);
    add_word($urandom);
    frame.push_back(build_sum);
    run_frame("junk_prefix");

    start_frame(0);
    run_frame("count_zero");
    start_frame(MW + 1);
    run_frame("count_over_max");
    start_frame(MW);
    for (int i = 0; i < MW; i++) add_word($urandom);
    frame.push_back(build_sum);
    run_frame("count_max");
  endtask

  task automatic test_random_frames();
    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, MW);
      int junk = $urandom_range(0, 3);
      frame.delete();
      for (int j = 0; j < junk; j++) frame.push_back(8'($urandom_range(0, 8'hA4)));
      frame.push_back(8'hA5);
      frame.push_back(n[7:0]);
      frame.push_back(n[15:8]);
      build_sum = 8'h00;
      for (int i = 0; i < n; i++) add_word($urandom);
      if ($urandom_range(0, 1) == 1) frame.push_back(build_sum);
      else frame.push_back(build_sum + 8'($urandom_range(1, 255)));
      run_frame("random_frame");
    end
  endtask

  task automatic test_timeout();
    int delay;
    start_frame(1);
    frame.push_back(8'h11);
    frame.push_back(8'h22);
    run_frame("timeout");
    delay = tx_cyc - last_pop_cyc;
    total++;
    if (delay < TO || delay > TO + 4) begin
      bad++;
      $display("FAIL timeout-delay: got %0d cycles want %0d..%0d", delay, TO, TO + 4);
    end
  endtask

  task automatic test_tx_full();
    int k = 0;
    start_frame(1);
    add_word($urandom);
    frame.push_back(build_sum);
    clear_mon();
    model();
    bus.tx_full = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    foreach (frame[i]) rx_q.push_back(frame[i]);
    while (rx_q.size() != 0 && k < 1000) begin @(negedge clk); k++; end
    repeat (50) @(negedge clk);
    total++;
    if (tx_q.size() != 0 || done !== 1'b0 || core_hold !== 1'b1) begin
      bad++;
      $display("FAIL tx_full-hold: tx=%0d done=%b hold=%b want 0 0 1", tx_q.size(), done, core_hold);
    end
    bus.tx_full = 1'b0;
    wait_end("tx_full");
    repeat (3) @(negedge clk);
    check_result("tx_full");
    release_enable("tx_full");
  endtask

  task automatic test_abort();
    int k = 0;
    clear_mon();
    start_frame(2);
    frame.push_back(8'h01);
    frame.push_back(8'h02);
    @(negedge clk);
    enable = 1'b1;
    foreach (frame[i]) rx_q.push_back(frame[i]);
    while (rx_q.size() != 0 && k < 1000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rx_q.push_back(8'h03);
    rx_q.push_back(8'h04);
    repeat (20) @(negedge clk);
    total++;
    if (wa_q.size() != 0 || tx_q.size() != 0 || rx_q.size() != 2 || core_hold !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL abort: writes=%0d tx=%0d rxleft=%0d hold=%b err=%b want 0 0 2 0 0",
               wa_q.size(), tx_q.size(), rx_q.size(), core_hold, err);
    end
    rx_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_mon();
    start_frame(2);
    for (int i = 0; i < 6; i++) frame.push_back(8'($urandom));
    @(negedge clk);
    enable = 1'b1;
    foreach (frame[i]) rx_q.push_back(frame[i]);
    while (rx_q.size() > 3 && k < 1000) begin @(negedge clk); k++; end
    Rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid");
    enable = 1'b0;
    @(negedge clk);
    Rst_n = 1'b1;
    rx_q.delete();
    repeat (3) @(negedge clk);
    total++;
    if (wa_q.size() != 0 || tx_q.size() != 0) begin
      bad++;
      $display("FAIL reset_mid-activity: writes=%0d tx=%0d want 0 0", wa_q.size(), tx_q.size());
    end
    start_frame(3);
    for (int i = 0; i < 3; i++) add_word($urandom);
    frame.push_back(build_sum);
    run_frame("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_frames();
    test_random_frames();
    test_timeout();
    test_tx_full();
    test_abort();
    test_reset_mid();
    total++;
    if (ren_viol != 0) begin
      bad++;
      $display("FAIL rx_ren-spacing: %0d back-to-back pops want 0", ren_viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
